// File: rtl/lemming_pkg.sv
// rtl/lemming_pkg.sv - shared types and constants for lemming bridge logic
package lemming_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLOW_LEFT  = 2'd1,
    FLOW_RIGHT = 2'd2,
    DRAIN      = 2'd3
  } bridge_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational N-way round-robin picker starting at a pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_pointer,
  output logic [N-1:0]  o_onehot,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  // Walk offsets from farthest to nearest so the nearest eligible index is written last.
  always_comb begin
    o_onehot = '0;
    o_valid  = 1'b0;
    o_index  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(i_pointer) + k;
      if (j >= N) j = j - N;
      if (i_eligible[j]) begin
        o_onehot    = '0;
        o_onehot[j] = 1'b1;
        o_valid     = 1'b1;
        o_index     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bridge_flow_scheduler.sv
// rtl/bridge_flow_scheduler.sv - one-lane bridge direction scheduler with drain-before-turnaround
module bridge_flow_scheduler
  import lemming_pkg::*;
#(
  parameter int N_LEM        = 4,
  parameter int CROSS_CYCLES = 8,
  parameter int MAX_BATCH    = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_LEM-1:0]                  req,
  input  logic [N_LEM-1:0]                  req_dir,
  output logic [N_LEM-1:0]                  grant,
  output logic                              flow_left,
  output logic                              flow_right,
  output logic                              draining,
  output logic [$clog2(CROSS_CYCLES+1)-1:0] occupancy
);

  localparam int PW = (N_LEM > 1) ? $clog2(N_LEM) : 1;
  localparam int BW = $clog2(MAX_BATCH + 1);
  localparam int OW = $clog2(CROSS_CYCLES + 1);

  bridge_state_t          r_state, w_next_state;
  logic [N_LEM-1:0]       r_grant, w_grant_next;
  logic [PW-1:0]          r_ptr;
  logic [BW-1:0]          r_batch;
  logic [CROSS_CYCLES-1:0] r_occ_sr;
  logic                   r_last_dir;
  logic                   r_flow_left, r_flow_right, r_draining;

  logic                   w_in_flow, w_cur_dir;
  logic [N_LEM-1:0]       w_elig_right, w_elig_left, w_same, w_opp, w_pick_in;
  logic [N_LEM-1:0]       w_win_onehot;
  logic                   w_win_valid;
  logic [PW-1:0]          w_win_idx;
  logic [OW-1:0]          w_occ;
  logic                   w_batch_inc, w_batch_clr;

  assign w_in_flow    = (r_state == FLOW_LEFT) || (r_state == FLOW_RIGHT);
  assign w_cur_dir    = (r_state == FLOW_RIGHT) ? DIR_RIGHT : DIR_LEFT;
  // The lemming granted last cycle is masked so its req has one cycle to drop.
  assign w_elig_right = req & req_dir & ~r_grant;
  assign w_elig_left  = req & ~req_dir & ~r_grant;
  assign w_same       = (w_cur_dir == DIR_RIGHT) ? w_elig_right : w_elig_left;
  assign w_opp        = (w_cur_dir == DIR_RIGHT) ? w_elig_left : w_elig_right;
  assign w_pick_in    = (r_state == IDLE) ? (req & ~r_grant) : w_same;

  rr_pick #(.N(N_LEM), .IW(PW)) u_rr_pick (
    .i_eligible (w_pick_in),
    .i_pointer  (r_ptr),
    .o_onehot   (w_win_onehot),
    .o_valid    (w_win_valid),
    .o_index    (w_win_idx)
  );

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < CROSS_CYCLES; i++) w_occ = w_occ + OW'(r_occ_sr[i]);
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_next = '0;
    w_batch_inc  = 1'b0;
    w_batch_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_next_state = req_dir[w_win_idx] ? FLOW_RIGHT : FLOW_LEFT;
          w_batch_clr  = 1'b1;
        end
      end
      FLOW_LEFT, FLOW_RIGHT: begin
        if ((|w_opp) && (!(|w_same) || (r_batch >= BW'(MAX_BATCH)))) begin
          w_next_state = DRAIN;
        end else if (w_win_valid) begin
          w_grant_next = w_win_onehot;
          w_batch_inc  = 1'b1;
        end else if ((w_occ == '0) && !(|req)) begin
          w_next_state = IDLE;
        end
      end
      DRAIN: begin
        if (w_occ == '0) begin
          w_next_state = (r_last_dir == DIR_RIGHT) ? FLOW_LEFT : FLOW_RIGHT;
          w_batch_clr  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_batch      <= '0;
      r_occ_sr     <= '0;
      r_last_dir   <= DIR_LEFT;
      r_flow_left  <= 1'b0;
      r_flow_right <= 1'b0;
      r_draining   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_grant      <= w_grant_next;
      r_occ_sr     <= (r_occ_sr << 1) | CROSS_CYCLES'(|w_grant_next);
      r_flow_left  <= (w_next_state == FLOW_LEFT);
      r_flow_right <= (w_next_state == FLOW_RIGHT);
      r_draining   <= (w_next_state == DRAIN);
      if (w_in_flow) r_last_dir <= w_cur_dir;
      if (w_batch_clr) begin
        r_batch <= '0;
      end else if (w_batch_inc && (r_batch != BW'(MAX_BATCH))) begin
        r_batch <= r_batch + 1'b1;
      end
      if (w_batch_inc) begin
        r_ptr <= (w_win_idx == PW'(N_LEM - 1)) ? '0 : w_win_idx + 1'b1;
      end
    end
  end

  assign grant      = r_grant;
  assign flow_left  = r_flow_left;
  assign flow_right = r_flow_right;
  assign draining   = r_draining;
  assign occupancy  = w_occ;

endmodule

// File: tb/tb_bridge_flow_scheduler.sv
// tb/tb_bridge_flow_scheduler.sv - directed self-checking bench for bridge_flow_scheduler
module tb_bridge_flow_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] req_dir;
  logic [3:0] grant;
  logic       flow_left;
  logic       flow_right;
  logic       draining;
  logic [3:0] occupancy;

  int total;
  int bad;

  bridge_flow_scheduler #(.N_LEM(4), .CROSS_CYCLES(8), .MAX_BATCH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_dir    (req_dir),
    .grant      (grant),
    .flow_left  (flow_left),
    .flow_right (flow_right),
    .draining   (draining),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    req     = '0;
    req_dir = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    total++;
    if ({flow_left, flow_right, draining} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {flow_left, flow_right, draining});
    end
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_single();
    logic [3:0] exp_g;
    logic [3:0] exp_o;
    logic       exp_fr;
    apply_reset();
    req = 4'b0100; req_dir = 4'b0100;
    for (int c = 1; c <= 11; c++) begin
      step();
      exp_g  = (c == 2) ? 4'b0100 : 4'b0000;
      exp_o  = (c >= 2 && c <= 9) ? 4'd1 : 4'd0;
      exp_fr = (c <= 10);
      total++;
      if (grant !== exp_g) begin bad++; $display("FAIL single_grant c=%0d got=%b want=%b", c, grant, exp_g); end
      total++;
      if (occupancy !== exp_o) begin bad++; $display("FAIL single_occ c=%0d got=%0d want=%0d", c, occupancy, exp_o); end
      total++;
      if (flow_right !== exp_fr) begin bad++; $display("FAIL single_flow c=%0d got=%b want=%b", c, flow_right, exp_fr); end
      req = req & ~grant;
    end
  endtask

  task automatic test_all_right_wrap();
    logic [3:0] exp_g;
    apply_reset();
    req = 4'b1111; req_dir = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      step();
      case (c)
        2: exp_g = 4'b0001;
        3: exp_g = 4'b0010;
        4: exp_g = 4'b0100;
        5: exp_g = 4'b1000;
        7: exp_g = 4'b0001;
        8: exp_g = 4'b1000;
        default: exp_g = 4'b0000;
      endcase
      total++;
      if (grant !== exp_g) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, grant, exp_g); end
      if (c == 5) begin
        total++;
        if (occupancy !== 4'd4) begin bad++; $display("FAIL rr_peak_occ got=%0d want=4", occupancy); end
      end
      req = req & ~grant;
      if (c == 6) req = 4'b1001;
    end
  endtask

  task automatic test_turnaround();
    logic [3:0] exp_g;
    apply_reset();
    req = 4'b1011; req_dir = 4'b0011;
    for (int c = 1; c <= 14; c++) begin
      step();
      case (c)
        2:  exp_g = 4'b0001;
        3:  exp_g = 4'b0010;
        13: exp_g = 4'b1000;
        default: exp_g = 4'b0000;
      endcase
      total++;
      if (grant !== exp_g) begin bad++; $display("FAIL turn_grant c=%0d got=%b want=%b", c, grant, exp_g); end
      total++;
      if (draining !== (c >= 4 && c <= 11)) begin bad++; $display("FAIL turn_drain c=%0d got=%b", c, draining); end
      total++;
      if (flow_left !== (c >= 12)) begin bad++; $display("FAIL turn_left c=%0d got=%b", c, flow_left); end
      if (c == 10 || c == 11) begin
        total++;
        if (occupancy !== ((c == 10) ? 4'd1 : 4'd0)) begin
          bad++; $display("FAIL turn_occ c=%0d got=%0d want=%0d", c, occupancy, (c == 10) ? 1 : 0);
        end
      end
      req = req & ~grant;
    end
  endtask

  task automatic test_batch_limit();
    logic [3:0] exp_g;
    logic       exp_d;
    apply_reset();
    req = 4'b1111; req_dir = 4'b0111;
    for (int c = 1; c <= 27; c++) begin
      step();
      case (c)
        2, 24, 27: exp_g = 4'b0001;
        3, 25:     exp_g = 4'b0010;
        4, 26:     exp_g = 4'b0100;
        14:        exp_g = 4'b1000;
        default:   exp_g = 4'b0000;
      endcase
      exp_d = (c >= 5 && c <= 12) || (c >= 15 && c <= 22);
      total++;
      if (grant !== exp_g) begin bad++; $display("FAIL batch_grant c=%0d got=%b want=%b", c, grant, exp_g); end
      total++;
      if (draining !== exp_d) begin bad++; $display("FAIL batch_drain c=%0d got=%b want=%b", c, draining, exp_d); end
      total++;
      if (flow_left !== (c == 13 || c == 14)) begin bad++; $display("FAIL batch_left c=%0d got=%b", c, flow_left); end
      req = req & ~(grant & 4'b1000);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [3:0] exp_g;
    apply_reset();
    req = 4'b0111; req_dir = 4'b0111;
    for (int c = 1; c <= 7; c++) begin
      step();
      case (c)
        2, 5: exp_g = 4'b0001;
        3, 6: exp_g = 4'b0010;
        4:    exp_g = 4'b0100;
        default: exp_g = 4'b0000;
      endcase
      total++;
      if (grant !== exp_g) begin bad++; $display("FAIL mid_grant c=%0d got=%b want=%b", c, grant, exp_g); end
      if (c == 6) req = 4'b1111;
    end
    total++;
    if (draining !== 1'b1) begin bad++; $display("FAIL mid_draining got=%b want=1", draining); end
    total++;
    if (occupancy !== 4'd5) begin bad++; $display("FAIL mid_occ got=%0d want=5", occupancy); end
    reset = 1'b1; req = '0; req_dir = '0;
    step();
    reset = 1'b0;
    total++;
    if ({grant, flow_left, flow_right, draining} !== 7'b0) begin
      bad++; $display("FAIL mid_reset_out got=%b want=0000000", {grant, flow_left, flow_right, draining});
    end
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("FAIL mid_reset_occ got=%0d want=0", occupancy); end
    req = 4'b0010; req_dir = 4'b0000;
    step();
    total++;
    if (flow_left !== 1'b1 || grant !== 4'b0000) begin
      bad++; $display("FAIL restart_c1 got flow_left=%b grant=%b want 1/0000", flow_left, grant);
    end
    step();
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL restart_grant got=%b want=0010", grant); end
    req = '0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    req     = '0;
    req_dir = '0;
    test_reset();
    test_single();
    test_all_right_wrap();
    test_turnaround();
    test_batch_limit();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bridge_flow_scheduler.md
Name: bridge_flow_scheduler

Overview:
- Shares a one-lane bridge between N lemming walkers. Each walker requests passage with a walking direction.
- Only one direction may be on the bridge at a time. Several lemmings may be on it at once, all going the same way.
- The block round-robin grants entries, tracks bridge occupancy, and drains the bridge before a turnaround.
- It sits between the per-lemming walk FSMs and the shared bridge segment of the level model.

Parameters:
- N_LEM, 4, number of requesting lemmings.
- CROSS_CYCLES, 8, cycles a granted lemming occupies the bridge (>=1).
- MAX_BATCH, 3, maximum consecutive same-direction grants while an opposite request is pending (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N_LEM  per-lemming passage request, level
- req_dir  in  N_LEM  per-lemming direction, 1=right, 0=left; valid while req high
- grant  out  N_LEM  registered one-hot entry grant, one-cycle pulse
- flow_left  out  1  bridge in left-flow state
- flow_right  out  1  bridge in right-flow state
- draining  out  1  bridge in drain state (turnaround pending)
- occupancy  out  $clog2(CROSS_CYCLES+1)  lemmings currently on the bridge

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- Reset (any state, including mid-drain):
  - state=IDLE, grant=0, occupancy tracker cleared, rr pointer=0, batch_cnt=0.
  - From the next cycle: flow_left=flow_right=draining=0 and occupancy=0.
- States: IDLE, FLOW_LEFT, FLOW_RIGHT, DRAIN. flow_left, flow_right and draining are registered decodes of the state.
- Eligibility:
  - Lemming i is eligible for direction d when req[i]=1, req_dir[i]=d and grant[i]=0 in the current cycle.
  - Masking the just-granted lemming allows one cycle for its req to drop.
  - same_pending = any lemming eligible for the current direction; opp_pending = any lemming eligible for the opposite direction.
- IDLE:
  - If any req is high, the round-robin pick from the pointer selects a lemming; go to FLOW_<its direction>.
  - No grant is issued on that edge.
  - Latency from IDLE: req in cycle 0, flow state in cycle 1, grant in cycle 2.
- FLOW_d, at each edge, in priority order:
  - (a) If opp_pending and (!same_pending or batch_cnt>=MAX_BATCH): go to DRAIN, no grant.
  - (b) Else if same_pending: grant the round-robin pick, batch_cnt++ (saturating), pointer = winner+1 mod N_LEM.
  - (c) Else if occupancy==0 and no req: go to IDLE.
  - Otherwise hold.
- DRAIN:
  - No grants.
  - When occupancy==0 this cycle, go to FLOW_<opposite of last flow> and set batch_cnt=0.
  - Opposite requests that vanish meanwhile are not re-checked; the block enters the opposite flow anyway. (c) then returns it to IDLE.
- Round robin: search indices pointer, pointer+1, ... wrapping at N_LEM; first eligible index wins. Only a grant moves the pointer.
- Grant rate: at most one grant per cycle.
- Occupancy tracker:
  - CROSS_CYCLES-bit shift register; the grant edge injects 1.
  - A lemming counts in occupancy for exactly CROSS_CYCLES cycles, starting in the cycle its grant is visible.
  - occupancy = popcount. It never exceeds CROSS_CYCLES.
- Entering FLOW resets batch_cnt to 0.
- Invariants: grant is always one-hot or zero. grant is never nonzero outside FLOW_d. Any lemming granted in FLOW_d has req_dir=d.
- A req that drops before its grant is simply dropped; there is no latched request.

Decomposition:
- Shared package lemming_pkg:
  - bridge_state_t enum (IDLE, FLOW_LEFT, FLOW_RIGHT, DRAIN).
  - Constants DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module rr_pick: parameterised N-way round-robin picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot winner, valid, winner index.
  - Purely combinational; reused by later lemming arbiters.
- The FSM, batch counter and occupancy shift register stay in bridge_flow_scheduler.

Test Plan (N_LEM=4, CROSS_CYCLES=8, MAX_BATCH=3):
- req=0100, dir right at cycle 0, dropped on grant:
  - flow_right=1 at cycle 1; grant=0100 at cycle 2 only.
  - occupancy=1 cycles 2-9, 0 at cycle 10; back to IDLE (flow_right=0) at cycle 11.
- req=1111 all right, each dropped on grant -> grant 0001, 0010, 0100, 1000 at cycles 2-5; occupancy peaks at 4.
- req=1011, dirs right/right/-/left:
  - Right grants: 0001 at cycle 2, 0010 at cycle 3.
  - Drain: draining=1 cycles 4-11; occupancy reaches 0 at cycle 11.
  - Left flow: flow_left=1 at cycle 12, grant=1000 at cycle 13.
- Lemmings 0-2 hold req right continuously (re-request), lemming 3 left from cycle 0:
  - Exactly 3 right grants, then DRAIN, then grant=1000.
  - After the next drain, right resumes with the pointer-rotated order.
- reset asserted during DRAIN with occupancy=5 -> next cycle all outputs 0 and state IDLE; a new req restarts with 2-cycle grant latency.
- Pointer wrap: after grant 1000, req=1001 same direction -> next grant 0001, not 1000.
